mem_split_resp: RTL and testbench

Memory-mapped responder for the MemSplit32 split-transaction bus: word-addressed RAM slave with byte-enabled writes, programmable wait states before `ack`, and a fixed-latency pipelined read-response path. It sits on a slave port of the tile arbiter as the data/instruction RAM or as a bench model of one. It must accept back-to-back reads from different masters while earlier reads are still in flight, because the bus has no backpressure on `resp`.

---
 rtl/mem_split_resp.sv | 69 ++++++
 tb/tb_mem_split_resp.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_split_resp.sv
// mem_split_resp: MemSplit32 RAM slave with byte-enabled writes, programmable wait
// states before ack and a fixed-latency pipelined read-response path.
module mem_split_resp #(
    parameter int MEM_WORDS   = 4096,
    parameter int RD_LATENCY  = 1,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [3:0]  host_be,
    input  logic [31:0] host_wdata,
    output logic        host_ack,
    output logic        host_resp,
    output logic [31:0] host_rdata
);
    localparam int AW = $clog2(MEM_WORDS);
    logic [31:0]           mem [MEM_WORDS];
    logic [AW-1:0]         widx;
    logic                  acc;
    logic [RD_LATENCY-1:0] vld_q;
    logic [31:0]           dat_q [RD_LATENCY];
    logic                  unused_addr;
    assign widx        = host_addr[AW+1:2];
    assign acc         = host_req && host_ack;
    assign unused_addr = ^{host_addr[31:AW+2], host_addr[1:0]};
    if (WAIT_STATES == 0) begin : g_nows
        assign host_ack = host_req && !rst_i;
    end else begin : g_ws
        typedef enum logic {IDLE, WAIT} state_t;
        state_t     state_q, state_d;
        logic [3:0] wcnt_q, wcnt_d;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                wcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                wcnt_q  <= wcnt_d;
            end
        end
        // Dropping req or being accepted both return to IDLE, so every request pays the full wait
        always_comb begin
            state_d = (state_q == IDLE) ? (host_req ? WAIT : IDLE) : ((host_req && !host_ack) ? WAIT : IDLE);
            wcnt_d  = (state_d == IDLE) ? 4'd0 : (state_q == IDLE) ? 4'd1 : wcnt_q + 4'd1;
        end
        always_comb host_ack = !rst_i && host_req && state_q == WAIT && wcnt_q == 4'(WAIT_STATES);
    end
    always_ff @(posedge clk_i) begin
        if (acc && host_we) begin
            for (int i = 0; i < 4; i++) begin
                if (host_be[i]) mem[widx][8*i +: 8] <= host_wdata[8*i +: 8];
            end
        end
    end
    // Reads and writes never accept together, so the unconditional read sees the settled word
    always_ff @(posedge clk_i) begin
        vld_q[0] <= !rst_i && acc && !host_we;
        dat_q[0] <= mem[widx];
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_q[i] <= !rst_i && vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
        end
    end
    assign host_resp  = vld_q[RD_LATENCY-1];
    assign host_rdata = host_resp ? dat_q[RD_LATENCY-1] : '0;
endmodule

// File: tb/tb_mem_split_resp.sv
// tb_mem_split_resp: directed checks of ack timing, byte enables, read pipelining,
// address wrap and reset with reads in flight, across four parameterisations.
module tb_mem_split_resp;
    logic        clk = 1'b0;
    logic        rst [4];
    logic        req [4], we [4], ack [4], resp [4];
    logic [31:0] addr [4], wdata [4], rdata [4];
    logic [3:0]  be [4];
    logic [31:0] pre [4] = '{32'hC0DE_0000, 32'hC0DE_1111, 32'hC0DE_2222, 32'hC0DE_3333};
    int          n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;

    mem_split_resp #(.MEM_WORDS(4096), .RD_LATENCY(2), .WAIT_STATES(0)) u_rl2 (
        .clk_i(clk), .rst_i(rst[0]), .host_req(req[0]), .host_we(we[0]), .host_addr(addr[0]),
        .host_be(be[0]), .host_wdata(wdata[0]), .host_ack(ack[0]), .host_resp(resp[0]), .host_rdata(rdata[0]));
    mem_split_resp #(.MEM_WORDS(4096), .RD_LATENCY(3), .WAIT_STATES(0)) u_rl3 (
        .clk_i(clk), .rst_i(rst[1]), .host_req(req[1]), .host_we(we[1]), .host_addr(addr[1]),
        .host_be(be[1]), .host_wdata(wdata[1]), .host_ack(ack[1]), .host_resp(resp[1]), .host_rdata(rdata[1]));
    mem_split_resp #(.MEM_WORDS(4096), .RD_LATENCY(1), .WAIT_STATES(2)) u_ws2 (
        .clk_i(clk), .rst_i(rst[2]), .host_req(req[2]), .host_we(we[2]), .host_addr(addr[2]),
        .host_be(be[2]), .host_wdata(wdata[2]), .host_ack(ack[2]), .host_resp(resp[2]), .host_rdata(rdata[2]));
    mem_split_resp #(.MEM_WORDS(16), .RD_LATENCY(4), .WAIT_STATES(0)) u_m16 (
        .clk_i(clk), .rst_i(rst[3]), .host_req(req[3]), .host_we(we[3]), .host_addr(addr[3]),
        .host_be(be[3]), .host_wdata(wdata[3]), .host_ack(ack[3]), .host_resp(resp[3]), .host_rdata(rdata[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
        req[k] = r; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    endtask

    // One bus cycle: inputs are already driven, sample mid-cycle, step past the next edge
    task automatic cyc(input int k, input string tag, input logic ea, input logic er, input logic [31:0] ed);
        @(negedge clk);
        chk({tag, ".ack"}, 32'(ack[k]), 32'(ea));
        chk({tag, ".resp"}, 32'(resp[k]), 32'(er));
        chk({tag, ".rdata"}, rdata[k], ed);
        @(posedge clk); #1;
    endtask

    task automatic quiet_all(input string tag);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s%0d.ack", tag, k), 32'(ack[k]), 32'h0);
            chk($sformatf("%s%0d.resp", tag, k), 32'(resp[k]), 32'h0);
            chk($sformatf("%s%0d.rdata", tag, k), rdata[k], 32'h0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1;
            drv(k, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        repeat (3) quiet_all("rst");
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b0;
            drv(k, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        repeat (3) quiet_all("post_rst");

        // Write then read on the next cycle, RD_LATENCY=2
        drv(0, 1, 1, 32'h10, 4'hF, 32'hDEADBEEF); cyc(0, "rw_wr", 1, 0, 0);
        drv(0, 1, 0, 32'h10, 4'h0, 32'h0);        cyc(0, "rw_rd", 1, 0, 0);
        drv(0, 0, 0, 32'h0, 4'h0, 32'h0);         cyc(0, "rw_t2", 0, 0, 0);
        cyc(0, "rw_t3", 0, 1, 32'hDEADBEEF);
        cyc(0, "rw_t4", 0, 0, 0);

        // Byte enables, including an all-zero enable that must change nothing
        drv(0, 1, 1, 32'h20, 4'hF, 32'h11223344);   cyc(0, "be_w1", 1, 0, 0);
        drv(0, 1, 1, 32'h20, 4'b0101, 32'hAABBCCDD); cyc(0, "be_w2", 1, 0, 0);
        drv(0, 1, 1, 32'h20, 4'h0, 32'hFFFFFFFF);   cyc(0, "be_w0", 1, 0, 0);
        drv(0, 1, 0, 32'h20, 4'hF, 32'h0);          cyc(0, "be_rd", 1, 0, 0);
        drv(0, 0, 0, 32'h0, 4'h0, 32'h0);           cyc(0, "be_t1", 0, 0, 0);
        cyc(0, "be_t2", 0, 1, 32'h11BB33DD);

        // Four back-to-back reads, RD_LATENCY=3
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 1, 32'(4*i), 4'hF, pre[i]);
            cyc(1, $sformatf("pre%0d", i), 1, 0, 0);
        end
        for (int c = 0; c < 8; c++) begin
            drv(1, c < 4, 0, 32'(4*c), 4'h0, 32'h0);
            cyc(1, $sformatf("pipe%0d", c), c < 4, c >= 3 && c <= 6,
                (c >= 3 && c <= 6) ? pre[c-3] : 32'h0);
        end

        // Wait states = 2: held write, then a read whose we flips during the wait
        drv(2, 1, 1, 32'h8, 4'hF, 32'h12345678);
        cyc(2, "ws_w0", 0, 0, 0); cyc(2, "ws_w1", 0, 0, 0); cyc(2, "ws_w2", 1, 0, 0);
        drv(2, 0, 0, 32'h0, 4'h0, 32'h0); cyc(2, "ws_w3", 0, 0, 0);
        drv(2, 1, 1, 32'hC, 4'hF, 32'h0BAD0BAD);
        cyc(2, "ws_r0", 0, 0, 0); cyc(2, "ws_r1", 0, 0, 0);
        drv(2, 1, 0, 32'h8, 4'h0, 32'h0); cyc(2, "ws_r2", 1, 0, 0);
        drv(2, 0, 0, 32'h0, 4'h0, 32'h0); cyc(2, "ws_r3", 0, 1, 32'h12345678);
        // Abandoned write, restarted count, then two held back-to-back reads
        drv(2, 1, 1, 32'h8, 4'hF, 32'hFFFFFFFF); cyc(2, "ab_d0", 0, 0, 0);
        drv(2, 0, 0, 32'h0, 4'h0, 32'h0);        cyc(2, "ab_d1", 0, 0, 0);
        drv(2, 1, 0, 32'h8, 4'h0, 32'h0);
        cyc(2, "ab_d2", 0, 0, 0); cyc(2, "ab_d3", 0, 0, 0); cyc(2, "ab_d4", 1, 0, 0);
        cyc(2, "ab_d5", 0, 1, 32'h12345678); cyc(2, "ab_d6", 0, 0, 0); cyc(2, "ab_d7", 1, 0, 0);
        drv(2, 0, 0, 32'h0, 4'h0, 32'h0);
        cyc(2, "ab_d8", 0, 1, 32'h12345678); cyc(2, "ab_d9", 0, 0, 0);

        // MEM_WORDS=16: 0x40 aliases word 0, as do high address bits and addr[1:0]
        drv(3, 1, 1, 32'h40, 4'hF, 32'h5A); cyc(3, "wrap_wr", 1, 0, 0);
        for (int c = 0; c < 7; c++) begin
            drv(3, c < 2, 0, (c == 0) ? 32'h0 : 32'h8000_0003, 4'h0, 32'h0);
            cyc(3, $sformatf("wrap%0d", c), c < 2, c == 4 || c == 5, (c == 4 || c == 5) ? 32'h5A : 32'h0);
        end

        // Reset one cycle after a read accept, RD_LATENCY=4: the response must vanish
        drv(3, 1, 0, 32'h0, 4'h0, 32'h0); cyc(3, "rst_rd", 1, 0, 0);
        rst[3] = 1'b1;                    cyc(3, "rst_hold", 0, 0, 0);
        rst[3] = 1'b0;
        drv(3, 0, 0, 32'h0, 4'h0, 32'h0);
        for (int c = 0; c < 6; c++) cyc(3, $sformatf("rst_after%0d", c), 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
